decode_byte_queue: RTL
======================

// Module: decode_byte_queue
// PURPOSE
//  Sequencer between instruction fetch and the combinational operand/opcode decoder.
//  Buffers fetched bytes and presents a 15-byte window at the head to the decoder.
//  When the decoder reports a complete instruction, the block registers it with its RIP
//  and pops the consumed bytes. Also handles backpressure, branch redirects and decode errors.
// PARAMETERS
//  BUF_BYTES    32     byte-queue capacity; power of 2, >= 2*FETCH_BYTES
//  FETCH_BYTES  8      bytes accepted per fetch beat
//  WIN_BYTES    15     decoder window (x86 max instruction length)
//  RESET_RIP    64'h0  RIP of the first byte after reset
// PORTS
//  clk            in   1    clock; all state changes on posedge
//  reset          in   1    synchronous, active-high
//  fetch_valid    in   1    fetch beat present
//  fetch_data     in   64   8 bytes; byte0 = [7:0] (lowest address)
//  fetch_ready    out  1    queue can take a full beat
//  win_bytes      out  120  head 15 bytes to decoder; byte0 = [7:0]; invalid bytes = 0
//  win_count      out  4    valid bytes in window = min(count,15)
//  dec_ok         in   1    decoder: complete instruction in window
//  dec_len        in   4    decoder: instruction length 1..15 (valid with dec_ok)
//  dec_err        in   1    decoder: undecodable bytes (illegal mode or -1 return)
//  out_valid      out  1    decoded instruction available
//  out_ready      in   1    downstream accepts
//  out_rip        out  64   RIP of the instruction
//  out_len        out  4    instruction length
//  out_bytes      out  120  instruction bytes; bytes >= out_len = 0
//  redirect_valid in   1    branch/flush request
//  redirect_rip   in   64   new fetch RIP
//  err_valid      out  1    decode fault latched
//  err_rip        out  64   RIP of faulting instruction
// BEHAVIOUR
//  Reset: count=0, head=0, rip=RESET_RIP, state=RUN, out_valid=0, out_*=0,
//   err_valid=0, err_rip=0. fetch_ready=1 from the first cycle after reset.
//  Queue: circular, head/tail pointers mod BUF_BYTES; count 0..BUF_BYTES.
//  fetch_ready = (count <= BUF_BYTES-FETCH_BYTES). Uses current count only; a pop in
//   the same cycle is not credited. A push is taken iff fetch_valid && fetch_ready.
//   fetch_valid while !fetch_ready is ignored (data dropped).
//  win_* is combinational from queue head. The decoder is combinational; dec_* is sampled
//   in the same cycle.
//  accept = state==RUN && dec_ok && (!out_valid || out_ready) && 1<=dec_len<=win_count.
//   On accept: out_valid<=1; out_rip<=rip; out_len<=dec_len; out_bytes<=masked window;
//   rip<=rip+dec_len (64-bit wrap); head+=dec_len; count-=dec_len.
//   Output hold: out_valid && !out_ready => out_* stay stable; nothing is popped.
//   Otherwise, out_valid && out_ready && !accept => out_valid<=0.
//  Same-cycle push and pop: count <= count + FETCH_BYTES - dec_len. Single cycle,
//   with no bubble. Throughput is 1 instruction/cycle when the window holds one.
//  No instruction yet (RUN, !dec_ok, !dec_err, win_count<15): wait for more bytes.
//  Fault (state RUN, evaluated only when (!out_valid || out_ready)):
//   dec_err; or dec_ok with dec_len==0 or dec_len>win_count; or win_count==15 && !dec_ok.
//   On fault: state<=HALT; err_valid<=1; err_rip<=rip. No pop. Any pending out_valid still
//   drains normally.
//  HALT: no accepts; fetch pushes still allowed. Leave only by redirect or reset.
//  Redirect (priority over everything else): next cycle count=0, head=tail=0,
//   rip=redirect_rip, out_valid=0, err_valid=0, state=RUN. A push in the same cycle is
//   discarded.
//  Reset mid-operation overrides redirect; all state returns to reset values.
// TESTING
//  1 NOPs: push 8x 0x90, decoder dec_len=1, out_ready=1 -> 8 outputs,
//    out_rip=RESET_RIP+0..7, out_len=1, then count=0, out_valid=0.
//  2 Straddle: 10-byte instruction split across 2 beats. After beat1 (win_count=8)
//    dec_ok=0 and no output. After beat2: out_len=10, out_rip=RESET_RIP, count=6.
//  3 Backpressure: out_ready=0 for 5 cycles with fetch streaming. out_* stay stable,
//    count stops at 32, fetch_ready=0 once count>24. On release, next instruction
//    follows with no bubble.
//  4 Simultaneous: count=20, push 8 and accept dec_len=3 in one cycle -> count=25.
//    Head bytes wrap correctly across pointer 31->0.
//  5 Redirect: with out_valid=1, count=17 and fetch_valid=1, pulse redirect_rip=0x4000 ->
//    next cycle out_valid=0, count=0, win_count=0; next accepted out_rip=0x4000.
//  6 Fault: dec_err at rip 0x1234 -> err_valid=1, err_rip=0x1234, no further out_valid.
//    15 bytes with no dec_ok also faults. A redirect clears err_valid.

Source files
------------

// File: rtl/decode_byte_queue_if.sv
// Fetch, decoder, instruction-out, redirect and fault signals of the decode byte queue.
// The queue is the slave; fetch, decoder and downstream logic form the master side.
interface decode_byte_queue_if;
  localparam int unsigned RIP_W   = 64;
  localparam int unsigned FETCH_W = 64;
  localparam int unsigned WIN_W   = 120;
  localparam int unsigned LEN_W   = 4;

  logic               fetch_valid;
  logic [FETCH_W-1:0] fetch_data;
  logic               fetch_ready;
  logic [WIN_W-1:0]   win_bytes;
  logic [LEN_W-1:0]   win_count;
  logic               dec_ok;
  logic [LEN_W-1:0]   dec_len;
  logic               dec_err;
  logic               out_valid;
  logic               out_ready;
  logic [RIP_W-1:0]   out_rip;
  logic [LEN_W-1:0]   out_len;
  logic [WIN_W-1:0]   out_bytes;
  logic               redirect_valid;
  logic [RIP_W-1:0]   redirect_rip;
  logic               err_valid;
  logic [RIP_W-1:0]   err_rip;

  modport slave (
    input  fetch_valid, fetch_data, dec_ok, dec_len, dec_err, out_ready,
           redirect_valid, redirect_rip,
    output fetch_ready, win_bytes, win_count, out_valid, out_rip, out_len,
           out_bytes, err_valid, err_rip
  );

  modport master (
    output fetch_valid, fetch_data, dec_ok, dec_len, dec_err, out_ready,
           redirect_valid, redirect_rip,
    input  fetch_ready, win_bytes, win_count, out_valid, out_rip, out_len,
           out_bytes, err_valid, err_rip
  );
endinterface

// File: rtl/decode_byte_queue.sv
// Byte queue between instruction fetch and a combinational decoder: presents the head
// window, registers each decoded instruction with its RIP, handles redirects and faults.
module decode_byte_queue #(
  parameter int unsigned BUF_BYTES   = 32,
  parameter int unsigned FETCH_BYTES = 8,
  parameter int unsigned WIN_BYTES   = 15,
  parameter logic [63:0] RESET_RIP   = 64'h0
) (
  input logic             clk,
  input logic             reset,
  decode_byte_queue_if.slave bus
);
  localparam int unsigned PW    = $clog2(BUF_BYTES);
  localparam int unsigned CW    = $clog2(BUF_BYTES + 1);
  localparam int unsigned LEN_W = 4;
  localparam int unsigned WIN_W = WIN_BYTES * 8;

  typedef enum logic {RUN, HALT} state_t;

  logic [7:0]       mem [BUF_BYTES];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [63:0]      rip;
  state_t           state;

  logic             out_valid_q;
  logic [63:0]      out_rip_q;
  logic [LEN_W-1:0] out_len_q;
  logic [WIN_W-1:0] out_bytes_q;
  logic             err_valid_q;
  logic [63:0]      err_rip_q;

  logic [WIN_W-1:0] win_flat;
  logic [WIN_W-1:0] win_masked;
  logic [LEN_W-1:0] win_cnt;
  logic             fetch_rdy;
  logic             can_adv;
  logic             len_ok;
  logic             accept;
  logic             fault;
  logic             push;
  logic [CW-1:0]    push_len;
  logic [CW-1:0]    pop_len;

  // Head window: bytes beyond the current fill level read as zero.
  always_comb begin
    win_flat   = '0;
    win_masked = '0;
    for (int i = 0; i < int'(WIN_BYTES); i++) begin
      if (CW'(i) < count) begin
        win_flat[i*8 +: 8] = mem[head + PW'(i)];
      end
      if (LEN_W'(i) < bus.dec_len) begin
        win_masked[i*8 +: 8] = win_flat[i*8 +: 8];
      end
    end
  end

  // Pops are not credited toward fetch_ready, keeping it a function of count alone.
  always_comb begin
    win_cnt   = (count >= CW'(WIN_BYTES)) ? LEN_W'(WIN_BYTES) : LEN_W'(count);
    fetch_rdy = (count <= CW'(BUF_BYTES - FETCH_BYTES));
    can_adv   = !out_valid_q || bus.out_ready;
    len_ok    = (bus.dec_len != '0) && (bus.dec_len <= win_cnt);
    accept    = (state == RUN) && can_adv && !bus.dec_err && bus.dec_ok && len_ok;
    fault     = (state == RUN) && can_adv &&
                (bus.dec_err || (bus.dec_ok && !len_ok) ||
                 (!bus.dec_ok && (win_cnt == LEN_W'(WIN_BYTES))));
    push      = bus.fetch_valid && fetch_rdy && !bus.redirect_valid && !reset;
    push_len  = push ? CW'(FETCH_BYTES) : '0;
    pop_len   = accept ? CW'(bus.dec_len) : '0;
  end

  // Byte storage needs no reset; the fill level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int j = 0; j < int'(FETCH_BYTES); j++) begin
        mem[tail + PW'(j)] <= bus.fetch_data[j*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rip         <= RESET_RIP;
      state       <= RUN;
      out_valid_q <= 1'b0;
      out_rip_q   <= '0;
      out_len_q   <= '0;
      out_bytes_q <= '0;
      err_valid_q <= 1'b0;
      err_rip_q   <= '0;
    end else if (bus.redirect_valid) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rip         <= bus.redirect_rip;
      state       <= RUN;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PW'(FETCH_BYTES);
      end
      count <= count + push_len - pop_len;
      if (accept) begin
        head        <= head + PW'(bus.dec_len);
        rip         <= rip + 64'(bus.dec_len);
        out_valid_q <= 1'b1;
        out_rip_q   <= rip;
        out_len_q   <= bus.dec_len;
        out_bytes_q <= win_masked;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A fault never pops; a pending output still drains on its own.
      if (fault) begin
        state       <= HALT;
        err_valid_q <= 1'b1;
        err_rip_q   <= rip;
      end
    end
  end

  assign bus.fetch_ready = fetch_rdy;
  assign bus.win_bytes   = win_flat;
  assign bus.win_count   = win_cnt;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rip     = out_rip_q;
  assign bus.out_len     = out_len_q;
  assign bus.out_bytes   = out_bytes_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_rip     = err_rip_q;
endmodule
